// File: rtl/projeto_maquinas_scheduler.sv
// projeto_maquinas_scheduler: round-robin scheduler granting 2 shared run slots to 4 machines with preemption and cooldown
module projeto_maquinas_scheduler #(
  parameter int MAX_RUN = 16,
  parameter int COOL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1,
  input  logic       m2,
  input  logic       m3,
  input  logic       m4,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic [1:0] active_cnt,
  output logic       wait_any
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RUN, S_COOL} st_t;
  st_t        st [4];
  st_t        st_n [4];
  logic [7:0] run_cnt [4];
  logic [7:0] run_n [4];
  logic [7:0] cool_cnt [4];
  logic [7:0] cool_n [4];
  logic [1:0] ptr, ptr_n, gidx, pidx, idx, act_n;
  logic [3:0] m, cand, stay, maxed, run_nv, wait_nv;
  logic       free, pre, gnt, found;
  assign m = {m4, m3, m2, m1};
  // next-state decision: releases, at most one preemption and at most one new grant per cycle
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cand[i] = st[i] == S_WAIT && m[i];
      stay[i] = st[i] == S_RUN && m[i];
      maxed[i] = stay[i] && run_cnt[i] == MAX_RUN[7:0];
    end
    free = (stay & (stay - 4'd1)) == 4'd0;
    pidx = 2'd0;
    for (int k = 3; k >= 0; k--) pidx = maxed[k] ? 2'(k) : pidx;
    pre = !free && |cand && |maxed;
    found = 1'b0;
    gidx = 2'd0;
    idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        gidx = idx;
      end
    end
    gnt = found && (free || pre);
    ptr_n = gnt ? gidx : ptr;
    for (int i = 0; i < 4; i++) begin
      st_n[i] = st[i];
      run_n[i] = run_cnt[i];
      cool_n[i] = cool_cnt[i];
      unique case (st[i])
        S_IDLE: st_n[i] = m[i] ? S_WAIT : S_IDLE;
        S_WAIT: begin
          st_n[i] = !m[i] ? S_IDLE : (gnt && gidx == 2'(i)) ? S_RUN : S_WAIT;
          run_n[i] = st_n[i] == S_RUN ? 8'd1 : 8'd0;
        end
        S_RUN: begin
          st_n[i] = !m[i] ? S_IDLE : (pre && pidx == 2'(i)) ? S_COOL : S_RUN;
          run_n[i] = st_n[i] != S_RUN ? 8'd0 : maxed[i] ? run_cnt[i] : run_cnt[i] + 8'd1;
          cool_n[i] = 8'(COOL - 1);
        end
        S_COOL: begin
          st_n[i] = cool_cnt[i] != 8'd0 ? S_COOL : m[i] ? S_WAIT : S_IDLE;
          cool_n[i] = cool_cnt[i] != 8'd0 ? cool_cnt[i] - 8'd1 : 8'd0;
        end
      endcase
      run_nv[i] = st_n[i] == S_RUN;
      wait_nv[i] = st_n[i] == S_WAIT;
    end
    act_n = {1'b0, run_nv[0]} + {1'b0, run_nv[1]} + {1'b0, run_nv[2]} + {1'b0, run_nv[3]};
  end
  // state, counters and registered outputs; pointer resets to machine 4 so the first search starts at machine 1
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        st[i] <= S_IDLE;
        run_cnt[i] <= 8'd0;
        cool_cnt[i] <= 8'd0;
      end
      ptr <= 2'd3;
      {c4, c3, c2, c1} <= 4'd0;
      active_cnt <= 2'd0;
      wait_any <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        st[i] <= st_n[i];
        run_cnt[i] <= run_n[i];
        cool_cnt[i] <= cool_n[i];
      end
      ptr <= ptr_n;
      {c4, c3, c2, c1} <= run_nv;
      active_cnt <= act_n;
      wait_any <= |wait_nv;
    end
  end
endmodule

// File: tb/tb_projeto_maquinas_scheduler.sv
// tb_projeto_maquinas_scheduler: directed self-checking bench for the machine scheduler
module tb_projeto_maquinas_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mv = 4'd0;
  logic       c1, c2, c3, c4, wait_any;
  logic [1:0] active_cnt;
  logic [3:0] g;
  int         checks = 0;
  int         failures = 0;
  assign g = {c4, c3, c2, c1};
  always #5 clk = ~clk;
  projeto_maquinas_scheduler #(.MAX_RUN(16), .COOL(4)) dut (
    .clk(clk), .rst(rst),
    .m1(mv[0]), .m2(mv[1]), .m3(mv[2]), .m4(mv[3]),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4),
    .active_cnt(active_cnt), .wait_any(wait_any)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_g", g, 0);
    chk("rst_act", active_cnt, 0);
    chk("rst_wait", wait_any, 0);
    rst = 1'b0;
    mv = 4'b1111;
    tick();
    chk("all_e0_g", g, 0);
    chk("all_e0_wait", wait_any, 1);
    tick();
    chk("all_e1_g", g, 4'b0001);
    chk("all_e1_act", active_cnt, 1);
    tick();
    chk("all_e2_g", g, 4'b0011);
    chk("all_e2_act", active_cnt, 2);
    chk("all_e2_wait", wait_any, 1);
    mv = 4'b1110;
    tick();
    chk("rel_g", g, 4'b0110);
    chk("rel_act", active_cnt, 2);
    chk("rel_wait", wait_any, 1);
    mv = 4'b0000;
    tick();
    chk("drop_g", g, 0);
    chk("drop_act", active_cnt, 0);
    chk("drop_wait", wait_any, 0);
    do_reset();
    mv = 4'b0001;
    tick();
    tick();
    chk("solo_act", active_cnt, 1);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("solo_g", g, 4'b0001);
      chk("solo_wait", wait_any, 0);
    end
    mv = 4'b0000;
    tick();
    chk("solo_off_g", g, 0);
    do_reset();
    mv = 4'b0111;
    tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("pre_c1_on", g[0], 1);
    end
    tick();
    chk("pre_swap_g", g, 4'b0110);
    chk("pre_swap_wait", wait_any, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("cool_g", g, 4'b0110);
      chk("cool_wait", wait_any, 0);
    end
    tick();
    chk("cool_end_wait", wait_any, 1);
    chk("cool_end_g", g, 4'b0110);
    tick();
    chk("pre2_g", g, 4'b0101);
    chk("pre2_wait", wait_any, 0);
    do_reset();
    mv = 4'b0100;
    tick();
    mv = 4'b0111;
    tick();
    chk("rs_a1_g", g, 4'b0100);
    tick();
    chk("rs_a2_g", g, 4'b0101);
    for (int k = 3; k <= 16; k++) begin
      tick();
      chk("rs_run_g", g, 4'b0101);
    end
    tick();
    chk("rs_a17_g", g, 4'b0011);
    chk("rs_a17_wait", wait_any, 0);
    tick();
    chk("rs_a18_g", g, 4'b0011);
    rst = 1'b1;
    tick();
    chk("rs_pulse_g", g, 0);
    chk("rs_pulse_act", active_cnt, 0);
    chk("rs_pulse_wait", wait_any, 0);
    rst = 1'b0;
    tick();
    chk("rs_r1_g", g, 0);
    chk("rs_r1_wait", wait_any, 1);
    tick();
    chk("rs_r2_g", g, 4'b0001);
    tick();
    chk("rs_r3_g", g, 4'b0011);
    mv = 4'b0000;
    do_reset();
    mv = 4'b0011;
    for (int k = 0; k < 34; k++) tick();
    chk("dual_sat_g", g, 4'b0011);
    mv = 4'b1111;
    tick();
    chk("dual_w_g", g, 4'b0011);
    chk("dual_w_wait", wait_any, 1);
    tick();
    chk("dual_p1_g", g, 4'b0110);
    chk("dual_p1_wait", wait_any, 1);
    chk("dual_p1_act", active_cnt, 2);
    tick();
    chk("dual_p2_g", g, 4'b1100);
    chk("dual_p2_wait", wait_any, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/projeto_maquinas_scheduler.md
PROJETO_MAQUINAS_SCHEDULER -- requirements
Module: projeto_maquinas_scheduler

Interface
REQ-001 SHALL have parameter MAX_RUN, default 16: maximum granted cycles before preemption when another machine waits (range 2..255).
REQ-002 SHALL have parameter COOL, default 4: cooldown cycles after a preemption (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports m1, m2, m3, m4  input  1 each  machine run requests; level, held high while the machine wants to run.
REQ-006 SHALL have ports c1, c2, c3, c4  output  1 each  registered run grants to machines 1..4.
REQ-007 SHALL have port active_cnt  output  2  number of grants currently high (0..2).
REQ-008 SHALL have port wait_any  output  1  registered; high when at least one machine is in WAIT.

Function
REQ-009 SHALL keep at most 2 of c1..c4 high in any cycle (shared capacity of 2).
REQ-010 SHALL give each machine i its own state: IDLE, WAIT, RUN, COOL.
REQ-011 SHALL move IDLE->WAIT in the cycle mi is sampled high; WAIT->IDLE if mi drops before a grant.
REQ-012 SHALL issue at most one new grant per cycle: mi sampled high in WAIT at edge N gives ci high from edge N+1 at the earliest (1-cycle minimum latency).
REQ-013 SHALL pick the new grantee round-robin among WAIT machines, searching from the index after the last granted machine; pointer resets to machine 1.
REQ-014 SHALL, when mi drops in RUN, lower ci on the next edge and move to IDLE with no cooldown.
REQ-015 SHALL count cycles with ci high in run_cnt (value 1 in first granted cycle), saturating at MAX_RUN.
REQ-016 SHALL preempt a RUN machine when run_cnt==MAX_RUN, a WAIT machine exists and no slot is free: ci falls on the next edge and the machine enters COOL.
REQ-017 SHALL let a RUN machine keep its grant past MAX_RUN while no other machine waits or a slot is free.
REQ-018 SHALL preempt at most one machine per cycle; lowest index first when several qualify.
REQ-019 SHALL make a slot freed by release or preemption available in the same decision: the old grant falls and the new grant rises on the same edge, never exceeding 2.
REQ-020 SHALL, in COOL, hold ci low and ignore mi for exactly COOL cycles, then go to WAIT if mi is high, else IDLE.
REQ-021 SHALL give release priority over preemption when both apply to one machine in the same cycle (IDLE, not COOL).
REQ-022 SHALL update active_cnt and wait_any in the same cycle as the grants they describe.

Reset
REQ-023 SHALL, with rst high at a rising edge, drive c1..c4=0, active_cnt=0 and wait_any=0, set all machines to IDLE, clear run_cnt and cooldown counters, and point round-robin at machine 1.
REQ-024 SHALL give rst priority over all other inputs, including mid-RUN or mid-COOL; requests held through reset are re-sampled from the first edge after rst falls.

Verification
REQ-025 SHALL verify: m1..m4 all rise together after reset -> c1 high at edge+1, c2 high at edge+2, c3 and c4 stay low, active_cnt=2, wait_any=1.
REQ-026 SHALL verify: with c1 and c2 granted and m3 waiting, m1 drops -> c1 low and c3 high on the same next edge, active_cnt stays 2.
REQ-027 SHALL verify: MAX_RUN=16 with m1, m2, m3 held high -> c1 high exactly 16 cycles, then falls as c3 rises; m1 ignored for 4 cycles, then WAIT.
REQ-028 SHALL verify: only m1 held high for 40 cycles -> c1 stays high throughout, no preemption, wait_any=0.
REQ-029 SHALL verify: rst pulsed for one cycle while c1 and c2 are high and m3 is in COOL -> all outputs 0 on the next edge; with m1..m3 held, c1 regrants at the second edge after rst falls.
REQ-030 SHALL verify: run_cnt of machines 1 and 2 both reach MAX_RUN with m3 and m4 waiting -> only machine 1 preempted that cycle; machine 2 preempted the following cycle.
